// File: rtl/wb_store_buffer_if.sv
// wb_store_buffer_if: bundles the LSU store-request handshake and the
// Wishbone master bus of the store buffer.
//   master : the store buffer's view (accepts requests, drives the bus)
//   slave  : the environment's view (LSU request side plus Wishbone slave)
interface wb_store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  localparam int SEL_W = DATA_WIDTH / 8;

  // LSU store request channel
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic [SEL_W-1:0]      req_we_i;

  // Wishbone write channel
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [SEL_W-1:0]      wb_sel_o;
  logic                  wb_gnt_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    input  req_we_i,
    output req_ready_o,
    output wb_cyc_o,
    output wb_stb_o,
    output wb_we_o,
    output wb_adr_o,
    output wb_dat_o,
    output wb_sel_o,
    input  wb_gnt_i,
    input  wb_ack_i,
    input  wb_err_i
  );

  modport slave (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    output req_we_i,
    input  req_ready_o,
    input  wb_cyc_o,
    input  wb_stb_o,
    input  wb_we_o,
    input  wb_adr_o,
    input  wb_dat_o,
    input  wb_sel_o,
    output wb_gnt_i,
    output wb_ack_i,
    output wb_err_i
  );

endinterface

// File: rtl/wb_store_buffer.sv
// wb_store_buffer: in-order store FIFO of DEPTH entries that drains one
// entry at a time as Wishbone write cycles, so stores retire without
// stalling the core. empty_o doubles as the drain/fence indicator.
//
// Optional feature macro: STORE_FWD_EN
//   defined   -> combinational store-to-load forwarding lookup on fwd_addr_i
//   undefined -> fwd_hit_o / fwd_data_o / fwd_sel_o tied to 0
module wb_store_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int SEL_W      = DATA_WIDTH / 8,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  wb_store_buffer_if.master     bus,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o,
  output logic                  err_o,
  input  logic [ADDR_WIDTH-1:0] fwd_addr_i,
  output logic                  fwd_hit_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [SEL_W-1:0]      fwd_sel_o
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  // FIFO storage
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [SEL_W-1:0]      r_sel  [DEPTH];

  // FIFO bookkeeping and bus FSM
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [0:0]       r_state;
  logic [0:0]       w_stateNext;

  logic w_ready;
  logic w_push;
  logic w_stb;
  logic w_pop;

  // Space is judged from the registered count only, so a same-cycle pop
  // never lets a full buffer accept.
  assign w_ready = (r_count < CNT_W'(DEPTH));

  // An all-zero byte-enable request completes the handshake but stores nothing.
  assign w_push  = bus.req_valid_i && w_ready && (|bus.req_we_i);

  // Strobe follows the grant while a cycle is in progress; losing the grant
  // simply holds the head entry.
  assign w_stb   = (r_state == ST_BUS) && bus.wb_gnt_i;

  // Either termination retires the head entry; error entries are not retried.
  assign w_pop   = w_stb && (bus.wb_ack_i || bus.wb_err_i);

  // Next-state logic: enter BUS whenever work is pending, leave only after
  // the last entry retires with nothing new arriving.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_stateNext = ST_BUS;
        end
      end
      ST_BUS: begin
        if (w_pop && (r_count == CNT_W'(1)) && !w_push) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // FSM state register; reset aborts any bus cycle immediately.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Pointer and occupancy update; both pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Entry payload write; contents are only meaningful while counted valid,
  // so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wrPtr] <= bus.req_addr_i;
      r_data[r_wrPtr] <= bus.req_data_i;
      r_sel[r_wrPtr]  <= bus.req_we_i;
    end
  end

  // Bus and status outputs, all driven from the head entry and registered state.
  assign bus.req_ready_o = w_ready;
  assign bus.wb_cyc_o    = (r_state == ST_BUS) || (r_count != '0);
  assign bus.wb_stb_o    = w_stb;
  assign bus.wb_we_o     = 1'b1;
  assign bus.wb_adr_o    = r_addr[r_rdPtr];
  assign bus.wb_dat_o    = r_data[r_rdPtr];
  assign bus.wb_sel_o    = w_stb ? r_sel[r_rdPtr] : '0;

  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign err_o   = w_stb && bus.wb_err_i;

`ifdef STORE_FWD_EN
  localparam int OFF = $clog2(SEL_W);

  logic [PTR_W-1:0]      w_fwdIdx;
  logic                  w_fwdHit;
  logic [DATA_WIDTH-1:0] w_fwdData;
  logic [SEL_W-1:0]      w_fwdSel;

  // Scan entries oldest to youngest so the youngest word-address match wins;
  // the head still counts as valid in the cycle it is popped.
  always_comb begin
    w_fwdIdx  = r_rdPtr;
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_fwdSel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwdIdx = r_rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) &&
          (r_addr[w_fwdIdx][ADDR_WIDTH-1:OFF] == fwd_addr_i[ADDR_WIDTH-1:OFF])) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_data[w_fwdIdx];
        w_fwdSel  = r_sel[w_fwdIdx];
      end
    end
  end

  assign fwd_hit_o  = w_fwdHit;
  assign fwd_data_o = w_fwdData;
  assign fwd_sel_o  = w_fwdSel;
`else
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
  assign fwd_sel_o  = '0;
`endif

endmodule

// File: tb/tb_wb_store_buffer.sv
// tb_wb_store_buffer: directed, table-driven bench for wb_store_buffer
// (DEPTH=4, 32-bit bus) with hand-written multi-cycle sequences.
module tb_wb_store_buffer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int CW = 3;

  logic          clk;
  logic          rstn_i;
  logic [CW-1:0] count_o;
  logic          empty_o;
  logic          err_o;
  logic [AW-1:0] fwd_addr_i;
  logic          fwd_hit_o;
  logic [DW-1:0] fwd_data_o;
  logic [SW-1:0] fwd_sel_o;

  int checks   = 0;
  int failures = 0;

  wb_store_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .bus        (bus),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .err_o      (err_o),
    .fwd_addr_i (fwd_addr_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_data_o (fwd_data_o),
    .fwd_sel_o  (fwd_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] we;
    logic          gnt;
    logic          ack;
    logic          err;
    logic          expReady;
    logic [CW-1:0] expCount;
    logic          expCyc;
    logic          expStb;
    logic [SW-1:0] expSel;
    logic          expErr;
    logic          chkBus;
    logic [AW-1:0] expAdr;
    logic [DW-1:0] expDat;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(
    input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] w,
    input logic g, input logic k, input logic e,
    input logic rdy, input logic [CW-1:0] cnt, input logic cyc, input logic stb,
    input logic [SW-1:0] sel, input logic eo, input logic cb,
    input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    vec_t r;
    r.valid = v; r.addr = a; r.data = d; r.we = w;
    r.gnt = g; r.ack = k; r.err = e;
    r.expReady = rdy; r.expCount = cnt; r.expCyc = cyc; r.expStb = stb;
    r.expSel = sel; r.expErr = eo; r.chkBus = cb; r.expAdr = ea; r.expDat = ed;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.req_valid_i = v.valid;
    bus.req_addr_i  = v.addr;
    bus.req_data_i  = v.data;
    bus.req_we_i    = v.we;
    bus.wb_gnt_i    = v.gnt;
    bus.wb_ack_i    = v.ack;
    bus.wb_err_i    = v.err;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushOne(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    bus.req_we_i    = 4'hF;
    nextCycle();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic setBus(input logic g, input logic k, input logic e);
    bus.wb_gnt_i = g;
    bus.wb_ack_i = k;
    bus.wb_err_i = e;
  endtask

  logic [AW-1:0] drainAddr [4];

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstn_i          = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_we_i    = '0;
    bus.wb_gnt_i    = 1'b0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;
    fwd_addr_i      = '0;

    // Single store, then fill/order, then zero-enable request
    vecs[0]  = mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 4'h0,                  1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 4'h0,                  1, 1, 0,  1, 1, 1, 1, 4'hF, 0, 1, 32'h100, 32'hDEADBEEF);
    vecs[3]  = mk(0, 0, 0, 4'h0,                  1, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 32'h0, 32'hA0, 4'hF,         0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 32'h4, 32'hA1, 4'hF,         0, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 32'h8, 32'hA2, 4'hF,         0, 0, 0,  1, 2, 1, 0, 4'h0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'hC, 32'hA3, 4'hF,         0, 0, 0,  1, 3, 1, 0, 4'h0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 32'h10, 32'hA4, 4'hF,        0, 0, 0,  0, 4, 1, 0, 4'h0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 4'h0,                  1, 1, 0,  0, 4, 1, 1, 4'hF, 0, 1, 32'h0, 32'hA0);
    vecs[10] = mk(0, 0, 0, 4'h0,                  1, 1, 0,  1, 3, 1, 1, 4'hF, 0, 1, 32'h4, 32'hA1);
    vecs[11] = mk(0, 0, 0, 4'h0,                  1, 1, 0,  1, 2, 1, 1, 4'hF, 0, 1, 32'h8, 32'hA2);
    vecs[12] = mk(0, 0, 0, 4'h0,                  1, 1, 0,  1, 1, 1, 1, 4'hF, 0, 1, 32'hC, 32'hA3);
    vecs[13] = mk(0, 0, 0, 4'h0,                  1, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[14] = mk(1, 32'h40, 32'h55, 4'h0,        0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 4'h0,                  0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Reset values
    #12;
    checkOutput("rst_ready", 64'(bus.req_ready_o), 64'd1);
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_empty", 64'(empty_o), 64'd1);
    checkOutput("rst_err",   64'(err_o), 64'd0);
    checkOutput("rst_cyc",   64'(bus.wb_cyc_o), 64'd0);
    checkOutput("rst_stb",   64'(bus.wb_stb_o), 64'd0);
    checkOutput("rst_sel",   64'(bus.wb_sel_o), 64'd0);
    nextCycle();
    rstn_i = 1'b1;

    // Table-driven rows: inputs applied for one cycle, outputs checked before the edge
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("row%0d_ready", i), 64'(bus.req_ready_o), 64'(vecs[i].expReady));
      checkOutput($sformatf("row%0d_count", i), 64'(count_o), 64'(vecs[i].expCount));
      checkOutput($sformatf("row%0d_empty", i), 64'(empty_o), 64'(vecs[i].expCount == 0));
      checkOutput($sformatf("row%0d_cyc", i),   64'(bus.wb_cyc_o), 64'(vecs[i].expCyc));
      checkOutput($sformatf("row%0d_stb", i),   64'(bus.wb_stb_o), 64'(vecs[i].expStb));
      checkOutput($sformatf("row%0d_sel", i),   64'(bus.wb_sel_o), 64'(vecs[i].expSel));
      checkOutput($sformatf("row%0d_errO", i),  64'(err_o), 64'(vecs[i].expErr));
      checkOutput($sformatf("row%0d_we", i),    64'(bus.wb_we_o), 64'd1);
      if (vecs[i].chkBus) begin
        checkOutput($sformatf("row%0d_adr", i), 64'(bus.wb_adr_o), 64'(vecs[i].expAdr));
        checkOutput($sformatf("row%0d_dat", i), 64'(bus.wb_dat_o), 64'(vecs[i].expDat));
      end
      nextCycle();
    end
    applyStimulus(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));

    // Full buffer with a same-cycle pop: no push until the next cycle
    pushOne(32'h20, 32'hB0);
    pushOne(32'h24, 32'hB1);
    pushOne(32'h28, 32'hB2);
    pushOne(32'h2C, 32'hB3);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h50;
    bus.req_data_i  = 32'hB4;
    bus.req_we_i    = 4'hF;
    setBus(1, 1, 0);
    #2;
    checkOutput("full_ready", 64'(bus.req_ready_o), 64'd0);
    checkOutput("full_count", 64'(count_o), 64'd4);
    checkOutput("full_stb",   64'(bus.wb_stb_o), 64'd1);
    checkOutput("full_adr",   64'(bus.wb_adr_o), 64'h20);
    nextCycle();
    setBus(0, 0, 0);
    #2;
    checkOutput("afterpop_ready", 64'(bus.req_ready_o), 64'd1);
    checkOutput("afterpop_count", 64'(count_o), 64'd3);
    nextCycle();
    bus.req_valid_i = 1'b0;
    #2;
    checkOutput("repush_count", 64'(count_o), 64'd4);
    drainAddr[0] = 32'h24; drainAddr[1] = 32'h28; drainAddr[2] = 32'h2C; drainAddr[3] = 32'h50;
    setBus(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      #2;
      checkOutput($sformatf("drain%0d_adr", k), 64'(bus.wb_adr_o), 64'(drainAddr[k]));
      nextCycle();
    end
    setBus(0, 0, 0);
    #2;
    checkOutput("drained_empty", 64'(empty_o), 64'd1);
    nextCycle();

    // Stray ack with stb low, then err+ack on the head
    pushOne(32'h60, 32'hC0);
    pushOne(32'h64, 32'hC1);
    setBus(0, 1, 0);
    #2;
    checkOutput("stray_stb",   64'(bus.wb_stb_o), 64'd0);
    checkOutput("stray_errO",  64'(err_o), 64'd0);
    checkOutput("stray_count", 64'(count_o), 64'd2);
    nextCycle();
    setBus(0, 0, 0);
    #2;
    checkOutput("stray_after_count", 64'(count_o), 64'd2);
    nextCycle();
    setBus(1, 1, 1);
    #2;
    checkOutput("err_stb",  64'(bus.wb_stb_o), 64'd1);
    checkOutput("err_errO", 64'(err_o), 64'd1);
    checkOutput("err_adr",  64'(bus.wb_adr_o), 64'h60);
    nextCycle();
    setBus(1, 0, 0);
    #2;
    checkOutput("post_err_errO",  64'(err_o), 64'd0);
    checkOutput("post_err_count", 64'(count_o), 64'd1);
    checkOutput("post_err_stb",   64'(bus.wb_stb_o), 64'd1);
    checkOutput("post_err_adr",   64'(bus.wb_adr_o), 64'h64);
    nextCycle();
    setBus(1, 1, 0);
    nextCycle();
    setBus(0, 0, 0);
    #2;
    checkOutput("post_err_empty", 64'(empty_o), 64'd1);
    nextCycle();

    // Reset in the middle of a bus cycle
    pushOne(32'h70, 32'hD0);
    pushOne(32'h74, 32'hD1);
    pushOne(32'h78, 32'hD2);
    setBus(1, 0, 0);
    #2;
    checkOutput("prerst_stb",   64'(bus.wb_stb_o), 64'd1);
    checkOutput("prerst_count", 64'(count_o), 64'd3);
    #1;
    rstn_i = 1'b0;
    #1;
    checkOutput("midrst_cyc",   64'(bus.wb_cyc_o), 64'd0);
    checkOutput("midrst_stb",   64'(bus.wb_stb_o), 64'd0);
    checkOutput("midrst_count", 64'(count_o), 64'd0);
    checkOutput("midrst_ready", 64'(bus.req_ready_o), 64'd1);
    nextCycle();
    rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput($sformatf("postrst%0d_cyc", k), 64'(bus.wb_cyc_o), 64'd0);
      checkOutput($sformatf("postrst%0d_stb", k), 64'(bus.wb_stb_o), 64'd0);
      nextCycle();
    end
    setBus(0, 0, 0);

`ifdef STORE_FWD_EN
    // Youngest matching entry wins at word granularity
    pushOne(32'h200, 32'h11);
    pushOne(32'h200, 32'h22);
    fwd_addr_i = 32'h202;
    #2;
    checkOutput("fwd_hit",  64'(fwd_hit_o), 64'd1);
    checkOutput("fwd_data", 64'(fwd_data_o), 64'h22);
    checkOutput("fwd_sel",  64'(fwd_sel_o), 64'hF);
    fwd_addr_i = 32'h300;
    #1;
    checkOutput("fwd_miss", 64'(fwd_hit_o), 64'd0);
`else
    // Forwarding disabled: outputs stay zero even with a matching entry
    pushOne(32'h200, 32'h11);
    fwd_addr_i = 32'h200;
    #2;
    checkOutput("fwd_off_hit",  64'(fwd_hit_o), 64'd0);
    checkOutput("fwd_off_data", 64'(fwd_data_o), 64'd0);
    checkOutput("fwd_off_sel",  64'(fwd_sel_o), 64'd0);
`endif
    nextCycle();
    setBus(1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
    end
    setBus(0, 0, 0);
    #2;
    checkOutput("final_empty", 64'(empty_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_store_buffer.md
Name: wb_store_buffer

Overview:
Parametrised, buffered successor of the single-shot store unit. It accepts store requests through a valid/ready handshake into an in-order FIFO of DEPTH entries and drains them one at a time as Wishbone write cycles. Stores therefore retire without stalling the core. It sits between the core's LSU and the Wishbone interconnect, with `empty_o` acting as the drain/fence indicator.

Parameters:
- DATA_WIDTH, 32, bus data width; must be a multiple of 8. Localparam SEL_W = DATA_WIDTH/8.
- ADDR_WIDTH, 32, bus address width.
- DEPTH, 4, FIFO entries; power of 2, ≥ 2. Localparam CNT_W = $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  buffer can accept a request
- req_addr_i  in  ADDR_WIDTH  store address
- req_data_i  in  DATA_WIDTH  store data
- req_we_i  in  SEL_W  byte enables
- count_o  out  CNT_W  number of occupied entries
- empty_o  out  1  no stores pending
- err_o  out  1  one-cycle pulse: the head store was terminated by wb_err_i
- wb_cyc_o  out  1  cycle in progress
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable, constant 1
- wb_adr_o  out  ADDR_WIDTH  head entry address
- wb_dat_o  out  DATA_WIDTH  head entry data
- wb_sel_o  out  SEL_W  head entry byte enables when stb is high, otherwise 0
- wb_gnt_i  in  1  bus grant
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error
- fwd_addr_i  in  ADDR_WIDTH  forwarding lookup address
- fwd_hit_o  out  1  forwarding hit
- fwd_data_o  out  DATA_WIDTH  forwarded data
- fwd_sel_o  out  SEL_W  forwarded byte enables

Behaviour:
- Reset (async, rstn_i=0):
  - FIFO pointers and count cleared; FSM in IDLE.
  - Outputs: req_ready_o=1, count_o=0, empty_o=1, err_o=0, wb_cyc_o=0, wb_stb_o=0, wb_sel_o=0.
  - Reset during a bus cycle drops cyc and stb immediately; all pending stores are discarded.
- Push:
  - A push occurs on a rising edge where req_valid_i && req_ready_o.
  - req_ready_o = (count < DEPTH), computed from registered count only. A same-cycle pop does not free space, so a full buffer never accepts.
  - A request with req_we_i == 0 completes the handshake but is not enqueued.
- Pop: occurs on an edge where wb_stb_o && (wb_ack_i || wb_err_i). The FIFO is strictly in-order.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE and BUS.
  - IDLE: wb_cyc_o = (count != 0). If count != 0, next state is BUS.
  - BUS: wb_cyc_o=1 and wb_stb_o = wb_gnt_i.
  - BUS: on a pop, go to IDLE if count==1 and there is no same-cycle push; otherwise stay in BUS and issue the next entry back-to-back.
- Latency: a push at edge N gives cyc high in cycle N+1 and, with gnt, stb high in cycle N+2. Sustained throughput is 1 store per cycle when ack is returned in the stb cycle.
- Bus signals:
  - wb_adr_o, wb_dat_o and wb_sel_o are stable while stb is high.
  - If gnt drops mid-transfer, stb follows it low and the entry is retained.
- Error and ack rules:
  - ack and err together: err wins; the entry is popped, err_o=1 for that cycle, and no retry is made.
  - ack or err while stb is low is ignored.
- empty_o = (count == 0).

Optional Feature:
STORE_FWD_EN.
- Defined:
  - Combinational lookup of fwd_addr_i against all valid entries, compared at word granularity (address bits above $clog2(SEL_W)).
  - On a match, fwd_hit_o=1 and fwd_data_o / fwd_sel_o come from the youngest matching entry.
  - Entries popped this cycle still match.
- Undefined: fwd_hit_o, fwd_data_o and fwd_sel_o are tied to 0, and fwd_addr_i is unused.

Test Plan:
- Single store: push addr=0x100, data=0xDEADBEEF, we=0xF with gnt=1 and ack on the first stb → stb in cycle +2, wb_sel_o=0xF, one pop, count 1→0, empty_o=1, FSM back to IDLE.
- Fill and order (DEPTH=4, gnt=0): 4 pushes → req_ready_o=0 and count_o=4; a 5th valid is held. Then gnt=1 with ack every cycle → addresses 0x0, 0x4, 0x8, 0xC issued in order on consecutive cycles.
- Full with pop: count=4 and an ack in the same cycle as req_valid_i → no push that cycle, count 4→3, push accepted next cycle.
- Error handling: wb_err_i=1 and wb_ack_i=1 on the head → err_o pulses 1 cycle, entry dropped, next entry issued. A stray ack with stb=0 → no change.
- Reset mid-cycle: 3 entries with stb high, then rstn_i=0 → cyc/stb=0 immediately and count_o=0. After release, no bus activity occurs.
- STORE_FWD_EN: pushes 0x200 with data 0x11 and then 0x200 with data 0x22, gnt=0, fwd_addr_i=0x202 → fwd_hit_o=1, fwd_data_o=0x22. A lookup at 0x300 → fwd_hit_o=0.
